// File: rtl/pulse_train_seq.sv
// Pulse-train sequencer: launches n delayed light pulses through an external
// delay generator, with a minimum low gap between pulses, a per-pulse
// watchdog and an immediate stop.
module pulse_train_seq #(
  parameter logic [23:0] PL_TMO  = 24'd10_000_000,
  parameter logic [7:0]  GAP_MIN = 8'd4
) (
  input  logic        clk_Seq,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  n_pulses,
  input  logic [16:0] delay_cfg,
  input  logic [4:0]  mlt_cfg,
  input  logic        dl_end,
  input  logic        pl_end,
  output logic        dl_launch,
  output logic [16:0] delay,
  output logic [4:0]  dl_mlt,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  pulse_cnt
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StDelay = 3'd2,
    StPulse = 3'd3,
    StGap   = 3'd4,
    StFin   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        start_q;
  logic        start_ok_q;
  logic        start_acc;
  logic [7:0]  n_q, n_d;
  logic [16:0] delay_q, delay_d;
  logic [4:0]  mlt_q, mlt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [23:0] wdog_q, wdog_d;
  logic [7:0]  gap_q, gap_d;
  logic        launch_q, launch_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // start_ok_q stays low after reset until start has been seen low, so a start
  // held high through reset release is not mistaken for a fresh edge.
  assign start_acc = start & ~start_q & start_ok_q & (state_q == StIdle);

  // Start edge-detect registers.
  always_ff @(posedge clk_Seq or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= 1'b0;
      start_ok_q <= 1'b0;
    end else begin
      start_q <= start;
      if (!start) start_ok_q <= 1'b1;
    end
  end

  // State, latched configuration, counters and registered outputs.
  always_ff @(posedge clk_Seq or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      n_q      <= 8'd0;
      delay_q  <= 17'd0;
      mlt_q    <= 5'd1;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
      wdog_q   <= 24'd0;
      gap_q    <= 8'd0;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      delay_q  <= delay_d;
      mlt_q    <= mlt_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
      gap_q    <= gap_d;
      launch_q <= launch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; stop overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    delay_d = delay_q;
    mlt_d   = mlt_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wdog_d  = 24'd0;
    gap_d   = 8'd0;

    case (state_q)
      StIdle: begin
        // Configuration is captured on the edge into ARM so it is valid in ARM.
        if (start_acc) begin
          state_d = StArm;
          n_d     = n_pulses;
          delay_d = delay_cfg;
          mlt_d   = mlt_cfg;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end
      end
      StArm: begin
        state_d = (n_q == 8'd0) ? StFin : StDelay;
      end
      StDelay: begin
        if (dl_end) state_d = StPulse;
      end
      StPulse: begin
        // pl_end wins over a simultaneous watchdog expiry.
        if (pl_end) begin
          state_d = StGap;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else if (wdog_q == PL_TMO - 24'd1) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + 24'd1;
        end
      end
      StGap: begin
        if ((gap_q >= GAP_MIN - 8'd1) && !dl_end) begin
          state_d = (cnt_q == n_q) ? StFin : StDelay;
        end else begin
          gap_d = (gap_q != 8'hFF) ? gap_q + 8'd1 : gap_q;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (stop && (state_q != StIdle)) begin
      state_d = StIdle;
      cnt_d   = cnt_q;
      err_d   = err_q;
      wdog_d  = 24'd0;
      gap_d   = 8'd0;
    end
  end

  // Outputs are registered from the next state so they align with the state.
  always_comb begin
    launch_d = (state_d == StDelay) || (state_d == StPulse);
    busy_d   = (state_d == StArm) || (state_d == StDelay) ||
               (state_d == StPulse) || (state_d == StGap);
    done_d   = (state_d == StFin);
  end

  assign dl_launch = launch_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign pulse_cnt = cnt_q;
  assign delay     = delay_q;
  assign dl_mlt    = mlt_q;

endmodule

// File: tb/tb_pulse_train_seq.sv
// Bench for pulse_train_seq with a behavioural delay/pulse generator model
// and a queue of expected end-of-train results.
module tb_pulse_train_seq;

  logic        clk_Seq = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  n_pulses = 8'd0;
  logic [16:0] delay_cfg = 17'd0;
  logic [4:0]  mlt_cfg = 5'd1;
  logic        dl_end;
  logic        pl_end;
  logic        dl_launch;
  logic [16:0] delay;
  logic [4:0]  dl_mlt;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  pulse_cnt;

  pulse_train_seq #(
    .PL_TMO (24'd100),
    .GAP_MIN(8'd4)
  ) dut (
    .clk_Seq  (clk_Seq),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .n_pulses (n_pulses),
    .delay_cfg(delay_cfg),
    .mlt_cfg  (mlt_cfg),
    .dl_end   (dl_end),
    .pl_end   (pl_end),
    .dl_launch(dl_launch),
    .delay    (delay),
    .dl_mlt   (dl_mlt),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .pulse_cnt(pulse_cnt)
  );

  always #5 clk_Seq = ~clk_Seq;

  // Generator model: dl_end gen_dly cycles after launch, pl_end 2 cycles later.
  int gen_cnt = 0;
  int gen_dly = 10;
  bit gen_pl_en = 1'b1;
  always @(posedge clk_Seq) gen_cnt <= dl_launch ? gen_cnt + 1 : 0;
  assign dl_end = dl_launch && (gen_cnt >= gen_dly);
  assign pl_end = gen_pl_en && dl_launch && (gen_cnt >= gen_dly + 2);

  // Monitor: done pulses, launch windows and shortest low run between windows.
  int   done_cnt = 0;
  int   win_cnt = 0;
  int   low_run = 0;
  int   min_low = 1000;
  logic prev_launch = 1'b0;
  always @(negedge clk_Seq) begin
    if (done) done_cnt++;
    if (dl_launch && !prev_launch) begin
      if (win_cnt > 0 && low_run < min_low) min_low = low_run;
      win_cnt++;
    end
    low_run = dl_launch ? 0 : low_run + 1;
    prev_launch = dl_launch;
  end

  typedef struct {
    logic [7:0] pcnt;
    logic       err;
    int         dones;
  } exp_t;
  exp_t exp_q[$];
  exp_t ex;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk_Seq);
    #1;
  endtask

  task automatic clr_mon();
    done_cnt = 0;
    win_cnt  = 0;
    min_low  = 1000;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({dl_launch, busy, done, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {dl_launch, busy, done, err});
    end
    n_tests++;
    if ({pulse_cnt, delay, dl_mlt} !== {8'd0, 17'd0, 5'd1}) begin
      n_fail++;
      $display("FAIL reset_values: got cnt=%0d delay=%0d mlt=%0d expected 0/0/1",
               pulse_cnt, delay, dl_mlt);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_three_pulse();
    bit ok;
    clr_mon();
    n_pulses = 8'd3; delay_cfg = 17'd10; mlt_cfg = 5'd1; gen_dly = 10;
    exp_q.push_back('{pcnt: 8'd3, err: 1'b0, dones: 1});
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL three_timeout: got busy=1 expected busy=0"); end
    n_tests++;
    if ({delay, dl_mlt} !== {17'd10, 5'd1}) begin
      n_fail++;
      $display("FAIL three_cfg: got %0d/%0d expected 10/1", delay, dl_mlt);
    end
    ex = exp_q.pop_front();
    n_tests++;
    if (pulse_cnt !== ex.pcnt) begin
      n_fail++; $display("FAIL three_cnt: got %0d expected %0d", pulse_cnt, ex.pcnt);
    end
    n_tests++;
    if (err !== ex.err) begin n_fail++; $display("FAIL three_err: got %b expected %b", err, ex.err); end
    n_tests++;
    if (done_cnt != ex.dones) begin
      n_fail++; $display("FAIL three_done: got %0d expected %0d", done_cnt, ex.dones);
    end
    n_tests++;
    if (win_cnt != 3) begin n_fail++; $display("FAIL three_windows: got %0d expected 3", win_cnt); end
    n_tests++;
    if (min_low < 4) begin n_fail++; $display("FAIL three_gap: got %0d expected >=4", min_low); end
  endtask

  task automatic test_zero_pulses();
    clr_mon();
    n_pulses = 8'd0;
    exp_q.push_back('{pcnt: 8'd0, err: 1'b0, dones: 1});
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if ({busy, done} !== 2'b10) begin
      n_fail++; $display("FAIL zero_arm: got busy,done=%b expected 10", {busy, done});
    end
    tick();
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done_cycle: got %b expected 1", done); end
    tick();
    tick();
    ex = exp_q.pop_front();
    n_tests++;
    if (win_cnt != 0) begin n_fail++; $display("FAIL zero_launch: got %0d expected 0", win_cnt); end
    n_tests++;
    if (pulse_cnt !== ex.pcnt) begin
      n_fail++; $display("FAIL zero_cnt: got %0d expected %0d", pulse_cnt, ex.pcnt);
    end
    n_tests++;
    if (done_cnt != ex.dones) begin
      n_fail++; $display("FAIL zero_done_cnt: got %0d expected %0d", done_cnt, ex.dones);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clr_mon();
    gen_dly = 5; gen_pl_en = 1'b0; n_pulses = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (dl_end) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL tmo_dl_end: got 0 expected 1"); end
    tick();  // first PULSE cycle
    repeat (99) tick();
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b expected 0", err); end
    tick();
    n_tests++;
    if ({err, busy, dl_launch} !== 3'b100) begin
      n_fail++; $display("FAIL tmo_abort: got err,busy,launch=%b expected 100", {err, busy, dl_launch});
    end
    tick();
    tick();
    n_tests++;
    if (done_cnt != 0) begin n_fail++; $display("FAIL tmo_no_done: got %0d expected 0", done_cnt); end
    gen_pl_en = 1'b1; gen_dly = 3; n_pulses = 8'd1;
    exp_q.push_back('{pcnt: 8'd1, err: 1'b0, dones: 1});
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b expected 0", err); end
    wait_idle(ok);
    ex = exp_q.pop_front();
    n_tests++;
    if ({ok, pulse_cnt, err} !== {1'b1, ex.pcnt, ex.err} || done_cnt != ex.dones) begin
      n_fail++;
      $display("FAIL tmo_next_train: got ok=%b cnt=%0d err=%b done=%0d expected 1/%0d/%b/%0d",
               ok, pulse_cnt, err, done_cnt, ex.pcnt, ex.err, ex.dones);
    end
  endtask

  task automatic test_stop();
    bit ok;
    clr_mon();
    n_pulses = 8'd5; delay_cfg = 17'd10; gen_dly = 10;
    exp_q.push_back('{pcnt: 8'd1, err: 1'b0, dones: 0});
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (win_cnt == 2) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL stop_reach: got windows=%0d expected 2", win_cnt); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    ex = exp_q.pop_front();
    n_tests++;
    if ({dl_launch, busy} !== 2'b00) begin
      n_fail++; $display("FAIL stop_outputs: got launch,busy=%b expected 00", {dl_launch, busy});
    end
    n_tests++;
    if (pulse_cnt !== ex.pcnt) begin
      n_fail++; $display("FAIL stop_cnt: got %0d expected %0d", pulse_cnt, ex.pcnt);
    end
    repeat (3) tick();
    n_tests++;
    if (done_cnt != ex.dones) begin
      n_fail++; $display("FAIL stop_done: got %0d expected %0d", done_cnt, ex.dones);
    end
  endtask

  task automatic test_cfg_change();
    bit ok;
    clr_mon();
    n_pulses = 8'd3; delay_cfg = 17'd10; mlt_cfg = 5'd1; gen_dly = 10;
    exp_q.push_back('{pcnt: 8'd3, err: 1'b0, dones: 1});
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    delay_cfg = 17'd500; mlt_cfg = 5'd2; n_pulses = 8'd7;
    repeat (5) tick();
    n_tests++;
    if ({delay, dl_mlt} !== {17'd10, 5'd1}) begin
      n_fail++; $display("FAIL cfg_mid: got %0d/%0d expected 10/1", delay, dl_mlt);
    end
    wait_idle(ok);
    ex = exp_q.pop_front();
    n_tests++;
    if ({ok, pulse_cnt, delay} !== {1'b1, ex.pcnt, 17'd10}) begin
      n_fail++;
      $display("FAIL cfg_end: got ok=%b cnt=%0d delay=%0d expected 1/%0d/10", ok, pulse_cnt, delay, ex.pcnt);
    end
    n_pulses = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if ({delay, dl_mlt} !== {17'd500, 5'd2}) begin
      n_fail++; $display("FAIL cfg_next: got %0d/%0d expected 500/2", delay, dl_mlt);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    clr_mon();
    n_pulses = 8'd3; delay_cfg = 17'd10; gen_dly = 10;
    start = 1'b1;
    tick();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (dl_end) begin ok = 1'b1; break; end
    end
    tick();  // now in PULSE
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ok, dl_launch, busy, done, err, pulse_cnt, delay, dl_mlt} !==
        {1'b1, 4'b0000, 8'd0, 17'd0, 5'd1}) begin
      n_fail++;
      $display("FAIL rstmid_values: got ok=%b flags=%b cnt=%0d delay=%0d mlt=%0d expected 1/0000/0/0/1",
               ok, {dl_launch, busy, done, err}, pulse_cnt, delay, dl_mlt);
    end
    @(posedge clk_Seq);
    #1 rst_n = 1'b1;
    repeat (6) tick();
    n_tests++;
    if ({busy, dl_launch} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_held_start: got busy,launch=%b expected 00", {busy, dl_launch});
    end
    start = 1'b0;
    tick();
    tick();
    exp_q.push_back('{pcnt: 8'd3, err: 1'b0, dones: 1});
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_restart: got %b expected 1", busy); end
    wait_idle(ok);
    ex = exp_q.pop_front();
    n_tests++;
    if ({ok, pulse_cnt} !== {1'b1, ex.pcnt} || done_cnt != ex.dones) begin
      n_fail++;
      $display("FAIL rstmid_train: got ok=%b cnt=%0d done=%0d expected 1/%0d/%0d",
               ok, pulse_cnt, done_cnt, ex.pcnt, ex.dones);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_three_pulse();
    test_zero_pulses();
    test_timeout();
    test_stop();
    test_cfg_change();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_train_seq.md
PULSE_TRAIN_SEQ -- requirements
Module: pulse_train_seq

Interface
REQ-001 Parameter: PL_TMO, 24'd10_000_000, max clk_Seq cycles allowed in PULSE state before timeout abort.
REQ-002 Parameter: GAP_MIN, 8'd4, min cycles dl_launch is held low between consecutive pulses.
REQ-003 clk_Seq  input  1  single system clock; all logic on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level; a rising edge while idle begins a train.
REQ-006 stop  input  1  level; aborts any running train.
REQ-007 n_pulses  input  8  pulses per train; sampled at start.
REQ-008 delay_cfg  input  17  delay count for the delay generator; sampled at start.
REQ-009 mlt_cfg  input  5  delay multiplier select (1 = x1, 2 = x100, other = x100000); sampled at start.
REQ-010 dl_end  input  1  end flag from the delay generator.
REQ-011 pl_end  input  1  level from the light-pulse generator; high when the pulse has been emitted.
REQ-012 dl_launch  output  1  launch/hold level to the delay generator.
REQ-013 delay  output  17  latched delay_cfg driven to the delay generator.
REQ-014 dl_mlt  output  5  latched mlt_cfg driven to the delay generator.
REQ-015 busy  output  1  high from ARM through GAP inclusive.
REQ-016 done  output  1  one-cycle pulse on normal train completion.
REQ-017 err  output  1  sticky timeout flag; cleared by the next accepted start.
REQ-018 pulse_cnt  output  8  pulses completed in the current or last train.

Function
REQ-019 start shall be edge-detected with a registered copy; only a 0->1 transition seen in IDLE is accepted, and edges in other states are ignored.
REQ-020 States shall be IDLE, ARM, DELAY, PULSE, GAP and FIN, with a binary encoding and an IDLE default branch for illegal codes.
REQ-021 IDLE->ARM on an accepted start; ARM shall latch n_pulses, delay_cfg and mlt_cfg, clear pulse_cnt and clear err.
REQ-022 ARM->FIN if latched n_pulses == 0, with no dl_launch asserted; otherwise ARM->DELAY.
REQ-023 In DELAY, dl_launch = 1; DELAY->PULSE on the first cycle dl_end = 1.
REQ-024 In PULSE, dl_launch stays 1 so the generator keeps its launch; PULSE->GAP on pl_end = 1, incrementing pulse_cnt in the same cycle.
REQ-025 In PULSE, a 24-bit watchdog counts from 0; on reaching PL_TMO-1 without pl_end, the block shall set err = 1 and go to IDLE with no done.
REQ-026 In GAP, dl_launch = 0; the gap counter runs from 0 and leaves GAP only when count >= GAP_MIN-1 and dl_end = 0.
REQ-027 On leaving GAP, go to FIN if pulse_cnt == latched n_pulses, else go to DELAY.
REQ-028 FIN shall assert done for exactly one cycle and then go to IDLE.
REQ-029 stop = 1 in any non-IDLE state shall go to IDLE on the next edge with dl_launch = 0 and no done; pulse_cnt holds its value; stop has priority over every other transition.
REQ-030 dl_launch, busy and done shall be registered outputs; dl_launch first goes high on the cycle after ARM.
REQ-031 delay and dl_mlt shall change only in ARM, and input changes mid-train have no effect.
REQ-032 pulse_cnt shall saturate at 255 and never wrap.
REQ-033 If pl_end and the watchdog expiry occur in the same cycle, pl_end wins: normal GAP entry, no err.

Reset
REQ-034 rst_n low shall asynchronously force IDLE and set dl_launch, busy, done, err to 0, pulse_cnt to 0, delay to 0, dl_mlt to 5'd1, and all counters and edge registers to 0.
REQ-035 Reset release mid-train shall leave the block in IDLE, and a start held high through the release shall not be accepted until it falls and rises again.

Verification
REQ-036 n_pulses=3, delay_cfg=10, mlt_cfg=1, generator model returns dl_end after 10 cycles and pl_end 2 cycles later -> three dl_launch high windows each separated by >= 4 low cycles, pulse_cnt = 3, one done pulse, err = 0.
REQ-037 n_pulses=0 with start -> done one cycle after ARM, dl_launch never high, pulse_cnt = 0.
REQ-038 PL_TMO=100, pl_end never asserted -> err = 1 exactly 100 cycles after PULSE entry, state IDLE, no done; the next start clears err.
REQ-039 stop asserted in the 2nd DELAY of a 5-pulse train -> dl_launch = 0 next cycle, busy = 0, pulse_cnt = 1, no done.
REQ-040 Change delay_cfg from 10 to 500 mid-train -> delay output stays 10 until the next start.
REQ-041 rst_n pulsed low for 1 cycle during PULSE, start held high -> all outputs at reset values, and no new train begins until start toggles.
